// File: rtl/flag_branch_unit.sv
// -----------------------------------------------------------------------------
// flag_branch_unit
//
// Condition-flag consumer for the 5-stage pipeline. This block does three jobs:
//   * It holds the architectural NZCV register. The EX stage writes it when an
//     ADDS/SUBS instruction completes.
//   * It resolves B, CBZ, CBNZ and B.cond for the instruction sitting in ID.
//   * It issues one registered taken/not-taken decision per accepted request
//     to the fetch-redirect logic, one cycle after acceptance.
//
// A flag hazard occurs when a B.cond in ID needs NZCV while EX is writing it
// in the same cycle. Two build options handle it:
//   FLAG_FWD_EN undefined (default): ID stalls for one cycle. The request is
//     resolved in the HOLD state, once the register holds the EX result.
//   FLAG_FWD_EN defined: B.cond evaluates ex_flags directly through a bypass.
//     id_stall stays 0 and the HOLD state is never entered.
// Flag-update timing and decision latency are the same in both builds.
//
// Reset is synchronous and active-low (reset_n).
// -----------------------------------------------------------------------------
module flag_branch_unit #(
    parameter int NUM_COND = 16
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        ex_valid,
    input  logic                        ex_set_flags,
    input  logic [3:0]                  ex_flags,
    input  logic                        id_valid,
    input  logic [1:0]                  id_br_type,
    input  logic [$clog2(NUM_COND)-1:0] id_cond,
    input  logic                        id_opnd_zero,
    input  logic                        flush,
    output logic                        id_stall,
    output logic                        br_valid,
    output logic                        br_taken,
    output logic [3:0]                  flags
);

    // Branch type encodings on id_br_type.
    localparam logic [1:0] BR_UNCOND = 2'b00;
    localparam logic [1:0] BR_CBZ    = 2'b01;
    localparam logic [1:0] BR_CBNZ   = 2'b10;
    localparam logic [1:0] BR_COND   = 2'b11;

    // Hazard FSM states.
    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    // Bit positions of the condition flags inside {N,Z,C,V}.
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    logic [0:0] state;
    logic [0:0] state_nxt;

    logic       flag_write;   // EX updates NZCV at the coming edge
    logic       is_bcond;     // ID request reads NZCV
    logic       flag_hazard;  // B.cond in ID while EX is writing NZCV
    logic       hold_req;     // hazard that must be resolved by stalling
    logic [3:0] src_flags;    // NZCV value the B.cond evaluation uses
    logic       stall;        // combinational stall towards ID
    logic       accept;       // request consumed this cycle
    logic       cond_true;    // B.cond condition result
    logic       taken;        // resolved direction of the ID request

    // -------------------------------------------------------------------------
    // ARM condition-code evaluation on a {N,Z,C,V} vector. AL and NV both
    // evaluate true.
    // -------------------------------------------------------------------------
    function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] nzcv);
        logic n;
        logic z;
        logic c;
        logic v;
        logic res;
        n = nzcv[FLAG_N];
        z = nzcv[FLAG_Z];
        c = nzcv[FLAG_C];
        v = nzcv[FLAG_V];
        case (cond)
            4'b0000: res = z;                 // EQ
            4'b0001: res = ~z;                // NE
            4'b0010: res = c;                 // HS
            4'b0011: res = ~c;                // LO
            4'b0100: res = n;                 // MI
            4'b0101: res = ~n;                // PL
            4'b0110: res = v;                 // VS
            4'b0111: res = ~v;                // VC
            4'b1000: res = c & ~z;            // HI
            4'b1001: res = ~c | z;            // LS
            4'b1010: res = (n == v);          // GE
            4'b1011: res = (n != v);          // LT
            4'b1100: res = ~z & (n == v);     // GT
            4'b1101: res = z | (n != v);      // LE
            default: res = 1'b1;              // AL, NV
        endcase
        return res;
    endfunction

    // Classify the ID request and detect a same-cycle NZCV write from EX.
    always_comb begin
        // NOTE: every signal written in an always_comb gets a value on every
        // path (here directly, elsewhere by a default first), so no latch is inferred.
        flag_write  = ex_valid & ex_set_flags;
        is_bcond    = (id_br_type == BR_COND);
        flag_hazard = id_valid & is_bcond & flag_write;
    end

`ifdef FLAG_FWD_EN
    // Bypass: a hazarding B.cond reads the ALU flags before they are registered.
    assign hold_req  = 1'b0;
    assign src_flags = flag_hazard ? ex_flags : flags;
`else
    // Stall: a hazarding B.cond waits one cycle and then reads the register.
    assign hold_req  = flag_hazard;
    assign src_flags = flags;
`endif

    // FSM next state and stall. A stall is raised only on entry to HOLD.
    // While reset is asserted, the stall is suppressed so that reset wins.
    always_comb begin
        state_nxt = state;
        stall     = 1'b0;
        case (state)
            ST_RUN: begin
                if (hold_req) begin
                    stall     = reset_n;
                    state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                // NZCV now holds the EX result, so the request is resolved here.
                state_nxt = ST_RUN;
            end
            default: begin
                state_nxt = ST_RUN;
            end
        endcase
    end

    assign id_stall = stall;
    assign accept   = id_valid & ~stall;

    // Resolve the branch direction for whatever sits in ID this cycle.
    always_comb begin
        cond_true = cond_eval(id_cond, src_flags);
        case (id_br_type)
            BR_UNCOND: taken = 1'b1;
            BR_CBZ:    taken = id_opnd_zero;
            BR_CBNZ:   taken = ~id_opnd_zero;
            BR_COND:   taken = cond_true;
            default:   taken = 1'b0;
        endcase
    end

    // Architectural NZCV register, written from the EX-stage ALU flags.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so that every
        // register samples pre-edge values, whatever the block order.
        if (!reset_n) begin
            flags <= 4'b0000;
        end else if (flag_write) begin
            flags <= ex_flags;
        end
    end

    // Hazard FSM state. A flush always returns the FSM to RUN.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= ST_RUN;
        end else if (flush) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Registered decision: valid for exactly one cycle after acceptance,
    // and squashed by a flush.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            br_valid <= 1'b0;
            br_taken <= 1'b0;
        end else begin
            br_valid <= accept & ~flush;
            br_taken <= accept & ~flush & taken;
        end
    end

endmodule

// File: tb/tb_flag_branch_unit.sv
// -----------------------------------------------------------------------------
// tb_flag_branch_unit
//
// Directed testbench for flag_branch_unit. All expected values are worked out
// by hand. The bench drives inputs 1 ns after each rising edge and samples the
// outputs at that same point. Define FLAG_FWD_EN to check the bypass build.
// -----------------------------------------------------------------------------
module tb_flag_branch_unit;

    logic       clk;
    logic       reset_n;
    logic       ex_valid;
    logic       ex_set_flags;
    logic [3:0] ex_flags;
    logic       id_valid;
    logic [1:0] id_br_type;
    logic [3:0] id_cond;
    logic       id_opnd_zero;
    logic       flush;
    logic       id_stall;
    logic       br_valid;
    logic       br_taken;
    logic [3:0] flags;

    int compared   = 0;
    int mismatched = 0;

    // Sweep vectors and the expected taken pattern for each one.
    // Bit i of each pattern is the result for cond code i.
    logic [3:0]  sweep_flags [5];
    logic [15:0] sweep_exp   [5];

    flag_branch_unit #(.NUM_COND(16)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .ex_valid     (ex_valid),
        .ex_set_flags (ex_set_flags),
        .ex_flags     (ex_flags),
        .id_valid     (id_valid),
        .id_br_type   (id_br_type),
        .id_cond      (id_cond),
        .id_opnd_zero (id_opnd_zero),
        .flush        (flush),
        .id_stall     (id_stall),
        .br_valid     (br_valid),
        .br_taken     (br_taken),
        .flags        (flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Backstop in case the sequence ever stops advancing.
    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000 ns");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        ex_valid     = 1'b0;
        ex_set_flags = 1'b0;
        ex_flags     = 4'b0000;
        id_valid     = 1'b0;
        id_br_type   = 2'b00;
        id_cond      = 4'b0000;
        id_opnd_zero = 1'b0;
        flush        = 1'b0;
    endtask

    initial begin
        logic [15:0] exp_word;

        sweep_flags[0] = 4'b0000; sweep_exp[0] = 16'hD6AA;
        sweep_flags[1] = 4'b0100; sweep_exp[1] = 16'hE6A9;
        sweep_flags[2] = 4'b1001; sweep_exp[2] = 16'hD65A;
        sweep_flags[3] = 4'b0010; sweep_exp[3] = 16'hD5A6;
        sweep_flags[4] = 4'b1111; sweep_exp[4] = 16'hE655;

        // ---- reset ----
        idle_inputs();
        reset_n = 1'b0;
        tick();
        tick();
        check4("reset flags", flags, 4'b0000);
        check1("reset br_valid", br_valid, 1'b0);
        check1("reset br_taken", br_taken, 1'b0);
        check1("reset id_stall", id_stall, 1'b0);
        reset_n = 1'b1;

        // ---- B.cond EQ with flags 0000 -> not taken ----
        id_valid = 1'b1; id_br_type = 2'b11; id_cond = 4'b0000;
        tick();
        check1("eq0 br_valid", br_valid, 1'b1);
        check1("eq0 br_taken", br_taken, 1'b0);
        check4("eq0 flags", flags, 4'b0000);
        id_valid = 1'b0;
        tick();
        check1("one-cycle br_valid", br_valid, 1'b0);

        // ---- SUBS sets Z, then EQ / NE with no hazard ----
        ex_valid = 1'b1; ex_set_flags = 1'b1; ex_flags = 4'b0100;
        tick();
        check4("subs z flags", flags, 4'b0100);
        ex_valid = 1'b0; ex_set_flags = 1'b0;
        id_valid = 1'b1; id_br_type = 2'b11; id_cond = 4'b0000;
        #1;
        check1("eq no-hazard id_stall", id_stall, 1'b0);
        tick();
        check1("eq z br_valid", br_valid, 1'b1);
        check1("eq z br_taken", br_taken, 1'b1);
        id_cond = 4'b0001;
        tick();
        check1("ne z br_valid", br_valid, 1'b1);
        check1("ne z br_taken", br_taken, 1'b0);
        id_valid = 1'b0;

        // ---- same-cycle hazard: SUBS 1000 with B.cond LT ----
        // Registered flags are 0100 here, so LT on them would be false.
        ex_valid = 1'b1; ex_set_flags = 1'b1; ex_flags = 4'b1000;
        id_valid = 1'b1; id_br_type = 2'b11; id_cond = 4'b1011;
        #1;
`ifdef FLAG_FWD_EN
        check1("hazard fwd id_stall", id_stall, 1'b0);
        tick();
        ex_valid = 1'b0; ex_set_flags = 1'b0; id_valid = 1'b0;
        check1("hazard fwd br_valid", br_valid, 1'b1);
        check1("hazard fwd br_taken", br_taken, 1'b1);
        check4("hazard fwd flags", flags, 4'b1000);
`else
        check1("hazard id_stall", id_stall, 1'b1);
        tick();
        ex_valid = 1'b0; ex_set_flags = 1'b0;
        check1("hazard bubble br_valid", br_valid, 1'b0);
        check4("hazard flags", flags, 4'b1000);
        #1;
        check1("hold id_stall", id_stall, 1'b0);
        tick();
        id_valid = 1'b0;
        check1("hold br_valid", br_valid, 1'b1);
        check1("hold br_taken", br_taken, 1'b1);
`endif
        tick();
        check1("post-hazard br_valid", br_valid, 1'b0);

        // ---- CBZ / CBNZ / B while EX writes flags: never a stall ----
        ex_valid = 1'b1; ex_set_flags = 1'b1; ex_flags = 4'b0000;
        id_valid = 1'b1; id_br_type = 2'b01; id_opnd_zero = 1'b1;
        #1;
        check1("cbz id_stall", id_stall, 1'b0);
        tick();
        check1("cbz br_valid", br_valid, 1'b1);
        check1("cbz br_taken", br_taken, 1'b1);
        id_br_type = 2'b10;
        #1;
        check1("cbnz id_stall", id_stall, 1'b0);
        tick();
        check1("cbnz br_valid", br_valid, 1'b1);
        check1("cbnz br_taken", br_taken, 1'b0);
        id_br_type = 2'b00;
        #1;
        check1("b id_stall", id_stall, 1'b0);
        tick();
        check1("b br_valid", br_valid, 1'b1);
        check1("b br_taken", br_taken, 1'b1);
        idle_inputs();

        // ---- sweep all 16 conditions across five flag vectors ----
        for (int v = 0; v < 5; v++) begin
            ex_valid = 1'b1; ex_set_flags = 1'b1; ex_flags = sweep_flags[v];
            id_valid = 1'b0;
            tick();
            check4($sformatf("sweep v%0d flags", v), flags, sweep_flags[v]);
            check1($sformatf("sweep v%0d idle br_valid", v), br_valid, 1'b0);
            ex_valid = 1'b0; ex_set_flags = 1'b0;
            exp_word = sweep_exp[v];
            for (int c = 0; c < 16; c++) begin
                id_valid = 1'b1; id_br_type = 2'b11; id_cond = 4'(c);
                tick();
                check1($sformatf("sweep v%0d c%0d br_valid", v, c), br_valid, 1'b1);
                check1($sformatf("sweep v%0d c%0d br_taken", v, c), br_taken, exp_word[c]);
            end
            id_valid = 1'b0;
        end

        // ---- flush in the accepting cycle squashes the decision ----
        idle_inputs();
        id_valid = 1'b1; id_br_type = 2'b00; flush = 1'b1;
        tick();
        check1("flush br_valid", br_valid, 1'b0);
        flush = 1'b0;
        tick();
        check1("after flush br_valid", br_valid, 1'b1);
        check1("after flush br_taken", br_taken, 1'b1);
        id_valid = 1'b0;

        // ---- reset while in HOLD (or mid-hazard in the bypass build) ----
        ex_valid = 1'b1; ex_set_flags = 1'b1; ex_flags = 4'b0110;
        id_valid = 1'b1; id_br_type = 2'b11; id_cond = 4'b0110;
        tick();
        check4("pre-reset flags", flags, 4'b0110);
        ex_valid = 1'b0; ex_set_flags = 1'b0;
        reset_n = 1'b0;
        tick();
        check4("reset-in-hold flags", flags, 4'b0000);
        check1("reset-in-hold br_valid", br_valid, 1'b0);
        check1("reset-in-hold br_taken", br_taken, 1'b0);
        reset_n = 1'b1;
        id_valid = 1'b0;
        #1;
        check1("reset-in-hold id_stall", id_stall, 1'b0);
        tick();
        check1("post-reset br_valid", br_valid, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
